// File: rtl/xgmii_frame_engine_if.sv
// XGMII, FIFO and status bundle for the XGMII frame engine.
// master is the engine side; slave is the XAUI/FIFO/user side.
interface xgmii_frame_engine_if #(
  parameter int CNT_W = 64
);
  logic [63:0]      xgmii_rxd;
  logic [7:0]       xgmii_rxc;
  logic [63:0]      xgmii_txd;
  logic [7:0]       xgmii_txc;
  logic             tx_fifo_rd_en;
  logic [63:0]      tx_fifo_rd_data;
  logic [1:0]       tx_fifo_rd_status;
  logic             rx_fifo_wr_en;
  logic [63:0]      rx_fifo_wr_data;
  logic [1:0]       rx_fifo_wr_status;
  logic             user_tx_en;
  logic             tx_strb;
  logic             rx_strb;
  logic             link_down_strb;
  logic [CNT_W-1:0] error_count;
  logic [CNT_W-1:0] data_count;

  modport master (
    input  xgmii_rxd,
    input  xgmii_rxc,
    input  tx_fifo_rd_data,
    input  tx_fifo_rd_status,
    input  rx_fifo_wr_status,
    input  user_tx_en,
    output xgmii_txd,
    output xgmii_txc,
    output tx_fifo_rd_en,
    output rx_fifo_wr_en,
    output rx_fifo_wr_data,
    output tx_strb,
    output rx_strb,
    output link_down_strb,
    output error_count,
    output data_count
  );

  modport slave (
    output xgmii_rxd,
    output xgmii_rxc,
    output tx_fifo_rd_data,
    output tx_fifo_rd_status,
    output rx_fifo_wr_status,
    output user_tx_en,
    input  xgmii_txd,
    input  xgmii_txc,
    input  tx_fifo_rd_en,
    input  rx_fifo_wr_en,
    input  rx_fifo_wr_data,
    input  tx_strb,
    input  rx_strb,
    input  link_down_strb,
    input  error_count,
    input  data_count
  );
endinterface

// File: rtl/xgmii_frame_engine.sv
// XGMII framing between the XAUI controller and the TX/RX FIFOs.
// TX wraps FIFO words in START/TERM; RX strips framing into the RX FIFO.
module xgmii_frame_engine #(
  parameter int MAX_WORDS = 16,
  parameter int CNT_W     = 64
) (
  input logic                 clk,
  input logic                 reset,
  xgmii_frame_engine_if.master bus
);
  localparam logic [63:0] IDLE_W  = 64'h0707070707070707;
  localparam logic [63:0] START_W = 64'hD5555555555555FB;
  localparam logic [63:0] TERM_W  = 64'h07070707070707FD;
  localparam logic [63:0] FAULT_W = 64'h0100009C0100009C;
  localparam int WW = $clog2(MAX_WORDS + 1);
  localparam logic [WW-1:0] MAXC = WW'(MAX_WORDS);

  typedef enum logic [2:0] {
    T_IDLE, T_START, T_DATA, T_TERM, T_GAP
  } tx_st_e;

  typedef enum logic {
    R_IDLE, R_DATA
  } rx_st_e;

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v
  );
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  tx_st_e           tx_st;
  logic [WW-1:0]    tx_cnt;
  logic [63:0]      txd_q;
  logic [7:0]       txc_q;
  logic             tx_strb_q;
  logic             tx_rd;
  logic             tx_empty;

  rx_st_e           rx_st;
  logic [WW-1:0]    rx_cnt;
  logic             wr_en_q;
  logic [63:0]      wr_data_q;
  logic             rx_strb_q;
  logic             ld_strb_q;
  logic             fault_prev;
  logic [CNT_W-1:0] err_q;
  logic [CNT_W-1:0] dcnt_q;

  logic             rx_start;
  logic             rx_term;
  logic             rx_data;
  logic             rx_fault;
  logic             rx_full;
  logic             rx_at_max;
  logic             unused_status;

  assign tx_empty  = bus.tx_fifo_rd_status[1];
  assign rx_full   = bus.rx_fifo_wr_status[1];
  assign unused_status = bus.tx_fifo_rd_status[0]
                       ^ bus.rx_fifo_wr_status[0];

  assign rx_start  = (bus.xgmii_rxc == 8'h01)
                   && (bus.xgmii_rxd[7:0] == 8'hFB);
  assign rx_term   = (bus.xgmii_rxc == 8'hFF)
                   && (bus.xgmii_rxd[7:0] == 8'hFD);
  assign rx_data   = (bus.xgmii_rxc == 8'h00);
  assign rx_fault  = (bus.xgmii_rxc == 8'h11)
                   && (bus.xgmii_rxd == FAULT_W);
  assign rx_at_max = (rx_cnt == MAXC);

  // Read one cycle ahead of the wire so data follows START with no gap.
  always_comb begin
    tx_rd = 1'b0;
    unique case (tx_st)
      T_START: tx_rd = !tx_empty;
      T_DATA:  tx_rd = !tx_empty && (tx_cnt < MAXC);
      default: tx_rd = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_st     <= T_IDLE;
      tx_cnt    <= '0;
      txd_q     <= IDLE_W;
      txc_q     <= 8'hFF;
      tx_strb_q <= 1'b0;
    end else begin
      tx_strb_q <= 1'b0;
      unique case (tx_st)
        T_IDLE: begin
          txd_q <= IDLE_W;
          txc_q <= 8'hFF;
          if (bus.user_tx_en && !tx_empty)
            tx_st <= T_START;
        end
        T_START: begin
          txd_q  <= START_W;
          txc_q  <= 8'h01;
          tx_cnt <= tx_rd ? WW'(1) : '0;
          tx_st  <= tx_rd ? T_DATA : T_TERM;
        end
        T_DATA: begin
          txd_q <= bus.tx_fifo_rd_data;
          txc_q <= 8'h00;
          if (tx_rd)
            tx_cnt <= tx_cnt + WW'(1);
          tx_st <= tx_rd ? T_DATA : T_TERM;
        end
        T_TERM: begin
          txd_q     <= TERM_W;
          txc_q     <= 8'hFF;
          tx_strb_q <= 1'b1;
          tx_st     <= T_GAP;
        end
        default: begin
          txd_q <= IDLE_W;
          txc_q <= 8'hFF;
          tx_st <= T_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_st      <= R_IDLE;
      rx_cnt     <= '0;
      wr_en_q    <= 1'b0;
      wr_data_q  <= '0;
      rx_strb_q  <= 1'b0;
      ld_strb_q  <= 1'b0;
      fault_prev <= 1'b0;
      err_q      <= '0;
      dcnt_q     <= '0;
    end else begin
      wr_en_q    <= 1'b0;
      rx_strb_q  <= 1'b0;
      fault_prev <= rx_fault;
      ld_strb_q  <= rx_fault && !fault_prev;
      unique case (rx_st)
        R_IDLE: begin
          if (rx_start) begin
            rx_st  <= R_DATA;
            rx_cnt <= '0;
          end
        end
        default: begin
          unique case (1'b1)
            rx_data && rx_at_max: begin
              err_q <= sat_inc(err_q);
              rx_st <= R_IDLE;
            end
            rx_data && !rx_at_max && rx_full: begin
              err_q <= sat_inc(err_q);
            end
            rx_data && !rx_at_max && !rx_full: begin
              wr_en_q   <= 1'b1;
              wr_data_q <= bus.xgmii_rxd;
              dcnt_q    <= sat_inc(dcnt_q);
              rx_cnt    <= rx_cnt + WW'(1);
            end
            rx_term: begin
              rx_strb_q <= 1'b1;
              rx_st     <= R_IDLE;
            end
            // A START mid-frame aborts the old frame and opens a new one.
            rx_start: begin
              err_q  <= sat_inc(err_q);
              rx_cnt <= '0;
            end
            default: begin
              err_q <= sat_inc(err_q);
              rx_st <= R_IDLE;
            end
          endcase
        end
      endcase
    end
  end

  assign bus.xgmii_txd       = txd_q;
  assign bus.xgmii_txc       = txc_q;
  assign bus.tx_fifo_rd_en   = tx_rd;
  assign bus.tx_strb         = tx_strb_q;
  assign bus.rx_fifo_wr_en   = wr_en_q;
  assign bus.rx_fifo_wr_data = wr_data_q;
  assign bus.rx_strb         = rx_strb_q;
  assign bus.link_down_strb  = ld_strb_q;
  assign bus.error_count     = err_q;
  assign bus.data_count      = dcnt_q;
endmodule

// File: tb/tb_xgmii_frame_engine.sv
// Randomized scoreboard bench for xgmii_frame_engine.
// TX frames and RX writes are predicted from framing rules and checked by monitors.
module tb_xgmii_frame_engine;
  localparam int MAXW = 5;
  localparam logic [63:0] IDLE_W  = 64'h0707070707070707;
  localparam logic [63:0] START_W = 64'hD5555555555555FB;
  localparam logic [63:0] TERM_W  = 64'h07070707070707FD;
  localparam logic [63:0] FAULT_W = 64'h0100009C0100009C;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  xgmii_frame_engine_if #(.CNT_W(64)) bus();

  xgmii_frame_engine #(
    .MAX_WORDS(MAXW),
    .CNT_W(64)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.master)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input bit ok, input string name,
                       input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // TX FIFO model: one-cycle read latency
  logic [63:0] tx_mem [0:255];
  int tx_wp = 0;
  int tx_rp = 0;
  int rd_pulses = 0;
  int exp_reads = 0;
  bit rd_q = 1'b0;
  logic [63:0] tx_rd_data = '0;

  assign bus.tx_fifo_rd_data = tx_rd_data;
  assign bus.tx_fifo_rd_status = {tx_wp == tx_rp, (tx_wp - tx_rp) <= 1};

  always @(negedge clk) begin
    rd_q = !reset && bus.tx_fifo_rd_en;
    if (rd_q) begin
      rd_pulses++;
      check(tx_wp != tx_rp, "rd_on_empty", 64'(tx_rp), 64'(tx_wp));
    end
  end

  always @(posedge clk) begin
    if (rd_q && tx_wp != tx_rp) begin
      tx_rd_data <= tx_mem[tx_rp % 256];
      tx_rp <= tx_rp + 1;
    end
  end

  // TX scoreboard
  logic [63:0] exp_words[$];
  int exp_len[$];
  logic [63:0] cur[$];
  bit in_frame = 1'b0;
  bit prev_term = 1'b0;
  int frames_done = 0;
  int starts = 0;
  int exp_frames = 0;

  always @(negedge clk) begin
    logic [63:0] d;
    logic [7:0] c;
    bit is_idle, is_start, is_term, is_data, ok;
    logic [63:0] a, e;
    int n;
    if (reset) begin
      in_frame = 1'b0;
      prev_term = 1'b0;
      cur.delete();
    end else begin
      d = bus.xgmii_txd;
      c = bus.xgmii_txc;
      is_idle  = (c == 8'hFF) && (d == IDLE_W);
      is_start = (c == 8'h01) && (d == START_W);
      is_term  = (c == 8'hFF) && (d == TERM_W);
      is_data  = (c == 8'h00);
      if (bus.tx_strb || is_term)
        check(bus.tx_strb && is_term, "tx_strb_vs_term",
              64'(bus.tx_strb), 64'(is_term));
      if (!in_frame) begin
        check(is_idle || is_start, "tx_idle_between", d, IDLE_W);
        if (is_start) begin
          check(!prev_term, "tx_gap_after_term", d, IDLE_W);
          in_frame = 1'b1;
          cur.delete();
          starts++;
        end
      end else begin
        check(is_data || is_term, "tx_in_frame_word", d, TERM_W);
        if (is_data) cur.push_back(d);
        else if (is_term) begin
          in_frame = 1'b0;
          frames_done++;
          check(exp_len.size() != 0, "tx_unexpected_frame",
                64'(cur.size()), 64'd0);
          if (exp_len.size() != 0) begin
            n = exp_len.pop_front();
            ok = (cur.size() == n);
            a = 64'(cur.size());
            e = 64'(n);
            for (int i = 0; i < n; i++) begin
              logic [63:0] w;
              w = exp_words.pop_front();
              if (ok && i < cur.size() && cur[i] != w) begin
                ok = 1'b0;
                a = cur[i];
                e = w;
              end
            end
            check(ok, "tx_frame", a, e);
          end
        end else begin
          in_frame = 1'b0;
        end
      end
      prev_term = is_term;
    end
  end

  task automatic load_tx(input int n);
    int rem;
    for (int i = 0; i < n; i++) begin
      logic [63:0] w;
      w = {$urandom, $urandom};
      tx_mem[tx_wp % 256] = w;
      tx_wp++;
      exp_words.push_back(w);
    end
    rem = n;
    while (rem > 0) begin
      exp_len.push_back(rem > MAXW ? MAXW : rem);
      rem -= MAXW;
      exp_frames++;
    end
    exp_reads += n;
  endtask

  task automatic wait_frames(input int target, input string name);
    int t = 0;
    while (frames_done < target && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check(frames_done >= target, name, 64'(frames_done), 64'(target));
  endtask

  // RX reference model and scoreboard
  logic [63:0] rxexp[$];
  int exp_err = 0, exp_dc = 0, exp_strb = 0, exp_ld = 0;
  int strb_seen = 0, ld_seen = 0;
  bit m_open = 1'b0, m_fprev = 1'b0;
  int m_cnt = 0;

  always @(negedge clk) begin
    if (!reset) begin
      if (bus.rx_fifo_wr_en) begin
        check(rxexp.size() != 0, "rx_unexpected_write",
              bus.rx_fifo_wr_data, 64'd0);
        if (rxexp.size() != 0) begin
          logic [63:0] w;
          w = rxexp.pop_front();
          check(bus.rx_fifo_wr_data == w, "rx_wr_data",
                bus.rx_fifo_wr_data, w);
        end
      end
      if (bus.rx_strb) strb_seen++;
      if (bus.link_down_strb) ld_seen++;
    end
  end

  task automatic rx_word(input logic [63:0] d, input logic [7:0] c,
                         input bit full);
    bit f, st, tm, dt;
    @(negedge clk);
    bus.xgmii_rxd = d;
    bus.xgmii_rxc = c;
    bus.rx_fifo_wr_status = {full, full};
    f  = (c == 8'h11) && (d == FAULT_W);
    st = (c == 8'h01) && (d[7:0] == 8'hFB);
    tm = (c == 8'hFF) && (d[7:0] == 8'hFD);
    dt = (c == 8'h00);
    if (f && !m_fprev) exp_ld++;
    m_fprev = f;
    if (!m_open) begin
      if (st) begin
        m_open = 1'b1;
        m_cnt = 0;
      end
    end else if (dt) begin
      if (m_cnt == MAXW) begin
        exp_err++;
        m_open = 1'b0;
      end else if (full) exp_err++;
      else begin
        rxexp.push_back(d);
        exp_dc++;
        m_cnt++;
      end
    end else if (tm) begin
      exp_strb++;
      m_open = 1'b0;
    end else if (st) begin
      exp_err++;
      m_cnt = 0;
    end else begin
      exp_err++;
      m_open = 1'b0;
    end
  endtask

  task automatic rx_idle();  rx_word(IDLE_W, 8'hFF, 1'b0); endtask
  task automatic rx_start(); rx_word(START_W, 8'h01, 1'b0); endtask
  task automatic rx_term();  rx_word(TERM_W, 8'hFF, 1'b0); endtask
  task automatic rx_fault(); rx_word(FAULT_W, 8'h11, 1'b0); endtask
  task automatic rx_data(input bit full);
    rx_word({$urandom, $urandom}, 8'h00, full);
  endtask

  task automatic rx_check(input string name);
    repeat (3) rx_idle();
    @(negedge clk);
    check(bus.error_count == 64'(exp_err), {name, "_err"},
          bus.error_count, 64'(exp_err));
    check(bus.data_count == 64'(exp_dc), {name, "_data_count"},
          bus.data_count, 64'(exp_dc));
    check(strb_seen == exp_strb, {name, "_rx_strb"},
          64'(strb_seen), 64'(exp_strb));
    check(ld_seen == exp_ld, {name, "_link_down"},
          64'(ld_seen), 64'(exp_ld));
    check(rxexp.size() == 0, {name, "_pending"},
          64'(rxexp.size()), 64'd0);
  endtask

  initial begin
    int f0, s0, t;
    logic [63:0] wb;
    bus.xgmii_rxd = IDLE_W;
    bus.xgmii_rxc = 8'hFF;
    bus.rx_fifo_wr_status = 2'b00;
    bus.user_tx_en = 1'b0;

    @(negedge clk);
    check(bus.xgmii_txd == IDLE_W, "reset_txd", bus.xgmii_txd, IDLE_W);
    check(bus.xgmii_txc == 8'hFF, "reset_txc", 64'(bus.xgmii_txc), 64'hFF);
    check({bus.tx_fifo_rd_en, bus.rx_fifo_wr_en, bus.tx_strb,
           bus.rx_strb, bus.link_down_strb} == 5'b0, "reset_strobes",
          64'({bus.tx_fifo_rd_en, bus.rx_fifo_wr_en, bus.tx_strb,
               bus.rx_strb, bus.link_down_strb}), 64'd0);
    check(bus.rx_fifo_wr_data == 64'd0, "reset_wr_data",
          bus.rx_fifo_wr_data, 64'd0);
    check(bus.error_count == 64'd0 && bus.data_count == 64'd0,
          "reset_counters", bus.error_count | bus.data_count, 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    fork
      begin
        load_tx(3);
        @(negedge clk);
        bus.user_tx_en = 1'b1;
        wait_frames(exp_frames, "tx_three_words");
        load_tx(12);
        wait_frames(exp_frames, "tx_word_limit");
        repeat (6) begin
          load_tx($urandom_range(1, 13));
          wait_frames(exp_frames, "tx_random");
        end
        repeat (4) @(negedge clk);
        bus.user_tx_en = 1'b0;
        load_tx(8);
        @(negedge clk);
        bus.user_tx_en = 1'b1;
        s0 = starts;
        t = 0;
        while (starts == s0 && t < 100) begin
          @(negedge clk);
          t++;
        end
        bus.user_tx_en = 1'b0;
        wait_frames(exp_frames - 1, "tx_en_drop_finishes");
        f0 = frames_done;
        s0 = starts;
        repeat (20) @(negedge clk);
        check(starts == s0, "tx_en_blocks_start", 64'(starts), 64'(s0));
        bus.user_tx_en = 1'b1;
        wait_frames(exp_frames, "tx_en_resume");
        check(frames_done == f0 + 1, "tx_resume_one_frame",
              64'(frames_done), 64'(f0 + 1));
      end
      begin
        rx_start();
        repeat (5) rx_data(1'b0);
        rx_term();
        rx_check("rx_frame5");
        rx_start();
        repeat (2) rx_data(1'b0);
        rx_start();
        repeat (3) rx_data(1'b0);
        rx_term();
        rx_check("rx_abort");
        rx_start();
        rx_data(1'b0);
        rx_data(1'b1);
        rx_data(1'b0);
        rx_data(1'b1);
        rx_term();
        rx_check("rx_overflow");
        rx_start();
        repeat (7) rx_data(1'b0);
        rx_term();
        rx_check("rx_word_limit");
        repeat (10) rx_fault();
        rx_idle();
        rx_start();
        repeat (2) rx_data(1'b0);
        rx_fault();
        rx_fault();
        rx_check("rx_fault");
        repeat (8) begin
          repeat ($urandom_range(0, 2)) rx_idle();
          if ($urandom_range(0, 2) == 0) rx_data(1'b0);
          rx_start();
          repeat ($urandom_range(1, 7))
            rx_data($urandom_range(0, 4) == 0);
          case ($urandom_range(0, 3))
            0: rx_term();
            1: rx_start();
            2: rx_word({$urandom, $urandom}, 8'hF0, 1'b0);
            default: rx_fault();
          endcase
        end
        rx_check("rx_random");
      end
    join

    // Reset in the middle of a TX frame
    repeat (4) @(negedge clk);
    bus.user_tx_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      logic [63:0] w;
      w = {$urandom, $urandom};
      if (i == 1) wb = w;
      tx_mem[tx_wp % 256] = w;
      tx_wp++;
    end
    exp_reads += 3;
    @(negedge clk);
    bus.user_tx_en = 1'b1;
    t = 0;
    while (!(bus.xgmii_txc == 8'h00 && bus.xgmii_txd == wb) && t < 100) begin
      @(negedge clk);
      t++;
    end
    check(t < 100, "rst_frame_seen", 64'(t), 64'd100);
    reset = 1'b1;
    #1;
    check(bus.xgmii_txd == IDLE_W, "rst_mid_txd", bus.xgmii_txd, IDLE_W);
    check(bus.xgmii_txc == 8'hFF, "rst_mid_txc",
          64'(bus.xgmii_txc), 64'hFF);
    check(!bus.tx_fifo_rd_en && !bus.tx_strb, "rst_mid_enables",
          64'({bus.tx_fifo_rd_en, bus.tx_strb}), 64'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    m_open = 1'b0;
    m_fprev = 1'b0;
    check(bus.error_count == 64'd0 && bus.data_count == 64'd0,
          "rst_counters_clear", bus.error_count | bus.data_count, 64'd0);
    f0 = frames_done;
    repeat (12) @(negedge clk);
    check(frames_done == f0, "rst_no_term", 64'(frames_done), 64'(f0));
    load_tx(4);
    wait_frames(frames_done + 1, "rst_next_frame");
    repeat (6) @(negedge clk);

    check(rd_pulses == exp_reads, "tx_rd_pulses",
          64'(rd_pulses), 64'(exp_reads));
    check(exp_len.size() == 0, "tx_frames_left",
          64'(exp_len.size()), 64'd0);
    check(tx_rp == tx_wp, "tx_fifo_drained", 64'(tx_rp), 64'(tx_wp));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
